imem_pipelined: RTL
===================

# imem_pipelined

Parametrised, writable instruction memory for the fetch stage of the single-cycle and pipelined cores. It accepts a PC plus fetch request, returns the instruction through a 1- or 2-stage read pipeline with a stall input, and supports run-time loading via a programming port. Words never written since reset, and PCs beyond the array, return a programmable default instruction. Out-of-range PCs are also flagged.

## Interface
- DATA_W, 16, instruction width in bits
- ADDR_W, 16, PC width in bits
- DEPTH, 256, number of words; addresses 0..DEPTH-1 valid; DEPTH <= 2^ADDR_W
- LATENCY, 1, read pipeline depth; legal values 1 or 2
- DEFAULT_INSTR, 16'hF001, word returned for unwritten or out-of-range addresses (JUMP 1)

- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc  in  ADDR_W  fetch address
- fetch_req  in  1  fetch request; sampled with pc on rising edge when stall=0
- stall  in  1  freezes the read pipeline and holds all fetch outputs
- instr  out  DATA_W  fetched instruction
- instr_valid  out  1  instr is the response to an accepted request
- addr_err  out  1  qualifies instr; response came from pc >= DEPTH
- prog_we  in  1  program write strobe
- prog_addr  in  ADDR_W  program write address
- prog_data  in  DATA_W  program write data
- prog_err  out  1  one-cycle pulse; last prog_we targeted prog_addr >= DEPTH (write dropped)

## Operation
- Storage is a DEPTH x DATA_W array plus a DEPTH-bit written flag vector. Reset clears the flags, not the array.
- Read result for address a:
  - a >= DEPTH: DEFAULT_INSTR with addr_err=1.
  - flag[a]=0: DEFAULT_INSTR with addr_err=0.
  - otherwise: mem[a].
- Write: on an edge with prog_we=1 and prog_addr < DEPTH, mem[prog_addr] <= prog_data and flag[prog_addr] <= 1. Writes are unaffected by stall.
- An out-of-range write leaves the array and flags untouched and pulses prog_err for one cycle.
- Read/write collision to the same address on the same edge is read-before-write: the fetch returns the prior contents, or DEFAULT_INSTR if the word was unwritten.
- Pipeline:
  - Stage 1 registers {valid, data, err} from the array lookup.
  - With LATENCY=2, a stage 2 re-registers stage 1.
  - instr, instr_valid and addr_err are driven from the last stage.
- stall=1: no stage advances, fetch_req is ignored (request dropped, not queued), and outputs hold their values exactly.
- A bubble (fetch_req=0 while stall=0) propagates as instr_valid=0. instr keeps its last value while invalid.

## Timing
- Reset (asynchronous assert): instr=0, instr_valid=0, addr_err=0, prog_err=0. All pipeline valids and all written flags clear immediately.
- Reset release: the first edge with rst_n=1 may accept a request and/or a write.
- LATENCY=1: a request accepted on edge k gives a valid response after edge k.
- LATENCY=2: a request accepted on edge k gives a valid response after edge k+1.
- Stall cycles add latency one-for-one.
- Throughput is one request per unstalled cycle, back-to-back, with no dead cycles.
- A write on edge k is visible to a request accepted on edge k+1 or later.
- prog_err rises after the offending edge and falls after the next edge unless that edge carries another out-of-range write.
- Reset mid-pipeline discards in-flight requests; none are reissued.
- Stall asserted in the same cycle as the last-stage response: the response stays on the outputs for the whole stall.

## Test plan
- Reset, then fetch pc=0..3 back-to-back with no writes (LATENCY=1) -> instr=16'hF001, instr_valid=1 on 4 consecutive cycles, addr_err=0.
- Write 16'h2456 at address 1 and 16'h6456 at address 2, then fetch pc=1,2 (LATENCY=2) -> 16'h2456 two edges after request, 16'h6456 the cycle after.
- Same edge: prog_we to address 5 with 16'h7105 and fetch pc=5 -> 16'hF001. Refetch pc=5 on the next cycle -> 16'h7105.
- Fetch pc=DEPTH (256) and write prog_addr=300 -> instr=16'hF001 with addr_err=1; prog_err pulses exactly one cycle; the array is unchanged.
- LATENCY=2 stream pc=1,2,3 with stall high for 3 cycles after the second accept, and fetch_req held high during the stall -> outputs frozen during the stall. The request presented during the stall is dropped. Response order is preserved.
- Deassert rst_n asynchronously between edges with two requests in flight -> instr_valid=0 and instr=0 immediately. A fetch of a previously written address then returns 16'hF001.

Source files
------------

// File: rtl/imem_pipelined.sv
// rtl/imem_pipelined.sv - writable instruction memory with 1- or 2-stage stallable read pipeline
module imem_pipelined #(
    parameter int                DATA_W        = 16,
    parameter int                ADDR_W        = 16,
    parameter int                DEPTH         = 256,
    parameter int                LATENCY       = 1,
    parameter logic [DATA_W-1:0] DEFAULT_INSTR = 16'hF001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_req,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_err,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    logic              rd_in_range;
    logic              wr_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] rd_word;

    assign rd_in_range = ({1'b0, pc} < (ADDR_W + 1)'(DEPTH));
    assign wr_in_range = ({1'b0, prog_addr} < (ADDR_W + 1)'(DEPTH));
    assign rd_idx      = pc[IDX_W-1:0];
    assign wr_idx      = prog_addr[IDX_W-1:0];

    always_comb begin
        rd_word = DEFAULT_INSTR;
        if (rd_in_range && written[rd_idx]) begin
            rd_word = mem[rd_idx];
        end
    end

    // The array itself is never reset; the written flags decide what a read sees.
    always_ff @(posedge clk) begin
        if (prog_we && wr_in_range) begin
            mem[wr_idx] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written  <= '0;
            prog_err <= 1'b0;
        end else begin
            prog_err <= prog_we && !wr_in_range;
            if (prog_we && wr_in_range) begin
                written[wr_idx] <= 1'b1;
            end
        end
    end

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_err;

    // Data and err only load on a real request so they hold through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_err   <= 1'b0;
        end else if (!stall) begin
            s1_valid <= fetch_req;
            if (fetch_req) begin
                s1_data <= rd_word;
                s1_err  <= !rd_in_range;
            end
        end
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic              s2_valid;
            logic [DATA_W-1:0] s2_data;
            logic              s2_err;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                    s2_err   <= 1'b0;
                end else if (!stall) begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                        s2_err  <= s1_err;
                    end
                end
            end

            assign instr       = s2_data;
            assign instr_valid = s2_valid;
            assign addr_err    = s2_err;
        end else begin : g_lat1
            assign instr       = s1_data;
            assign instr_valid = s1_valid;
            assign addr_err    = s1_err;
        end
    endgenerate

endmodule
